// File: rtl/sdram_bram_responder.sv
// ---------------------------------------------------------------------------
// sdram_bram_responder
//
// Responder end of the SDRAM request/response bus. It stands in for the real
// SDRAM controller. Storage is an on-chip byte-enabled block RAM of
// 2**WORD_ADDR_BITS 32-bit words. Address bits above the RAM size are ignored
// for storage, so addresses alias modulo the memory size. The full requested
// address is still echoed on sdram_raddress.
//
// Supported transactions:
//   - single-word write (byte enables, one per cycle, no response beat)
//   - single-word read (one beat)
//   - 16-beat line-aligned read burst (64 bytes)
// Read beats carry the master ID, the beat address and the 9-bit tag that was
// captured from wdata[8:0] when the request was accepted.
//
// Optional feature: define SDRAM_REFRESH_EN to emulate periodic refresh.
// The block then stalls for REFRESH_CYCLES cycles every REFRESH_INTERVAL
// cycles. A stall never splits a read, and it never coincides with an
// acceptance.
//
// Ports:
//   clk             in   system clock, rising edge
//   reset_n         in   asynchronous active-low reset
//   sdram_request   in   [2:0]  master ID of presented request, 0 = none
//   sdram_ready     out         request presented this cycle will be consumed
//   sdram_address   in   [25:0] byte address
//   sdram_write     in          1 = write, 0 = read
//   sdram_burst     in          1 = 16-beat read burst (ignored for writes)
//   sdram_wstrb     in   [3:0]  write byte enables
//   sdram_wdata     in   [31:0] write data; [8:0] is the tag for reads
//   sdram_rvalid    out  [2:0]  master ID of current read beat, 0 = none
//   sdram_raddress  out  [25:0] byte address of current beat
//   sdram_rdata     out  [31:0] read data
//   sdram_rtag      out  [8:0]  tag of current beat
//   sdram_complete  out         final beat of a transaction
// ---------------------------------------------------------------------------
module sdram_bram_responder #(
   parameter int WORD_ADDR_BITS   = 12,
   parameter int BURST_BEATS      = 16,
   parameter int REFRESH_INTERVAL = 512,
   parameter int REFRESH_CYCLES   = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  sdram_request,
   output logic        sdram_ready,
   input  logic [25:0] sdram_address,
   input  logic        sdram_write,
   input  logic        sdram_burst,
   input  logic [3:0]  sdram_wstrb,
   input  logic [31:0] sdram_wdata,
   output logic [2:0]  sdram_rvalid,
   output logic [25:0] sdram_raddress,
   output logic [31:0] sdram_rdata,
   output logic [8:0]  sdram_rtag,
   output logic        sdram_complete
);

`ifdef SDRAM_REFRESH_EN
   typedef enum logic [1:0] {IDLE, READ, STALL} state_t;
`else
   typedef enum logic {IDLE, READ} state_t;
`endif

   state_t      state;
   logic [2:0]  rd_id;
   logic [8:0]  rd_tag;
   logic [23:0] rd_addr;
   logic        rd_burst;
   logic [3:0]  beat_cnt;

   logic [31:0] mem [0:(1 << WORD_ADDR_BITS) - 1];

   logic                      accept;
   logic [WORD_ADDR_BITS-1:0] wr_idx;
   logic [23:0]               beat_word;
   logic [WORD_ADDR_BITS-1:0] rd_idx;
   logic                      last_beat;

   // Acceptance depends only on the registered ready, never on input timing.
   // A burst replaces the four low word-address bits with the beat counter,
   // which makes every burst line-aligned.
   always_comb begin
      accept    = sdram_ready && (sdram_request != 3'd0);
      wr_idx    = sdram_address[WORD_ADDR_BITS+1:2];
      beat_word = rd_burst ? {rd_addr[23:4], beat_cnt} : rd_addr;
      rd_idx    = beat_word[WORD_ADDR_BITS-1:0];
      last_beat = !rd_burst || (beat_cnt == 4'(BURST_BEATS - 1));
   end

   // Byte-enabled RAM write port. The RAM has no reset, so its contents
   // survive reset_n.
   always_ff @(posedge clk) begin
      if (accept && sdram_write) begin
         for (int b = 0; b < 4; b++) begin
            if (sdram_wstrb[b]) begin
               mem[wr_idx][8*b +: 8] <= sdram_wdata[8*b +: 8];
            end
         end
      end
   end

`ifdef SDRAM_REFRESH_EN
   localparam int RI_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
   localparam int SC_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

   logic [RI_W-1:0] refresh_cnt;
   logic [SC_W-1:0] stall_cnt;
   logic            refresh_tick;
   logic            refresh_pending;

   assign refresh_tick = (refresh_cnt == RI_W'(REFRESH_INTERVAL - 1));

   // Free-running refresh interval timer. Its tick only raises a pending
   // flag. The FSM honours the flag at a safe point.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         refresh_cnt <= '0;
      end else if (refresh_tick) begin
         refresh_cnt <= '0;
      end else begin
         refresh_cnt <= refresh_cnt + 1'b1;
      end
   end
`endif

   // Main controller. In IDLE it accepts requests. In READ it streams one beat
   // per cycle out of the RAM. The beat registers double as the RAM output
   // register, which gives the two-cycle first-beat latency and lets the
   // data outputs hold their last value between beats.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         sdram_ready    <= 1'b0;
         sdram_rvalid   <= 3'd0;
         sdram_complete <= 1'b0;
         sdram_raddress <= 26'd0;
         sdram_rdata    <= 32'd0;
         sdram_rtag     <= 9'd0;
         rd_id          <= 3'd0;
         rd_tag         <= 9'd0;
         rd_addr        <= 24'd0;
         rd_burst       <= 1'b0;
         beat_cnt       <= 4'd0;
`ifdef SDRAM_REFRESH_EN
         stall_cnt       <= '0;
         refresh_pending <= 1'b0;
`endif
      end else begin
         sdram_rvalid   <= 3'd0;
         sdram_complete <= 1'b0;
         case (state)
            IDLE: begin
               sdram_ready <= 1'b1;
               if (accept && !sdram_write) begin
                  rd_id       <= sdram_request;
                  rd_tag      <= sdram_wdata[8:0];
                  rd_addr     <= sdram_address[25:2];
                  rd_burst    <= sdram_burst;
                  beat_cnt    <= 4'd0;
                  sdram_ready <= 1'b0;
                  state       <= READ;
               end
`ifdef SDRAM_REFRESH_EN
               // Refresh waits for a cycle that has no acceptance.
               else if (refresh_pending && !accept) begin
                  refresh_pending <= 1'b0;
                  stall_cnt       <= '0;
                  sdram_ready     <= 1'b0;
                  state           <= STALL;
               end
`endif
            end
            READ: begin
               sdram_rvalid   <= rd_id;
               sdram_raddress <= {beat_word, 2'b00};
               sdram_rdata    <= mem[rd_idx];
               sdram_rtag     <= rd_tag;
               sdram_complete <= last_beat;
               // The counter holds at the final beat instead of wrapping.
               if (last_beat) begin
                  state <= IDLE;
               end else begin
                  beat_cnt <= beat_cnt + 4'd1;
               end
            end
`ifdef SDRAM_REFRESH_EN
            STALL: begin
               sdram_ready <= 1'b0;
               if (stall_cnt == SC_W'(REFRESH_CYCLES - 1)) begin
                  sdram_ready <= 1'b1;
                  state       <= IDLE;
               end else begin
                  stall_cnt <= stall_cnt + 1'b1;
               end
            end
`endif
            default: begin
               state <= IDLE;
            end
         endcase
`ifdef SDRAM_REFRESH_EN
         // A tick that lands while READ or STALL is busy is remembered. It is
         // then taken at the next IDLE cycle.
         if (refresh_tick) begin
            refresh_pending <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_sdram_bram_responder.sv
// ---------------------------------------------------------------------------
// tb_sdram_bram_responder
//
// Self-checking bench for sdram_bram_responder in its default build, with no
// refresh emulation. A table of request records is driven through
// applyStimulus. Each read pushes its expected beats, with the cycle each
// beat is due, onto a scoreboard queue. A negedge monitor pops the queue and
// compares every beat as it appears. Hand-written sequences cover reset
// behaviour, burst timing and the abandonment of a burst by reset.
// ---------------------------------------------------------------------------
module tb_sdram_bram_responder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  sdram_request;
   logic        sdram_ready;
   logic [25:0] sdram_address;
   logic        sdram_write;
   logic        sdram_burst;
   logic [3:0]  sdram_wstrb;
   logic [31:0] sdram_wdata;
   logic [2:0]  sdram_rvalid;
   logic [25:0] sdram_raddress;
   logic [31:0] sdram_rdata;
   logic [8:0]  sdram_rtag;
   logic        sdram_complete;

   always #5 clk = ~clk;

   sdram_bram_responder dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .sdram_request  (sdram_request),
      .sdram_ready    (sdram_ready),
      .sdram_address  (sdram_address),
      .sdram_write    (sdram_write),
      .sdram_burst    (sdram_burst),
      .sdram_wstrb    (sdram_wstrb),
      .sdram_wdata    (sdram_wdata),
      .sdram_rvalid   (sdram_rvalid),
      .sdram_raddress (sdram_raddress),
      .sdram_rdata    (sdram_rdata),
      .sdram_rtag     (sdram_rtag),
      .sdram_complete (sdram_complete)
   );

   typedef struct {
      bit          wr;
      bit          burst;
      logic [2:0]  id;
      logic [25:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      int          exp_wait;
   } vec_t;

   typedef struct {
      logic [2:0]  id;
      logic [25:0] addr;
      logic [31:0] data;
      logic [8:0]  tag;
      logic        complete;
      int          due;
   } beat_t;

   beat_t exp_q[$];
   int    vectors    = 0;
   int    miscompares = 0;
   int    cyc        = 0;
   bit    in_burst   = 1'b0;

   // Count rising edges. Beat k of a read accepted at edge E0 is due
   // when the count reaches E0+1+k.
   always @(posedge clk) cyc++;

   // Scoreboard monitor, sampled on the falling edge
   always @(negedge clk) begin
      beat_t b;
      if (!reset_n) begin
         in_burst = 1'b0;
         vectors++;
         if (sdram_rvalid != 3'd0 || sdram_complete) begin
            miscompares++;
            $display("[TB] FAIL beat during reset: rvalid=%0d complete=%b, want 0/0",
                     sdram_rvalid, sdram_complete);
         end
      end else if (sdram_rvalid != 3'd0) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected beat: id=%0d addr=%h data=%h, want no beat",
                     sdram_rvalid, sdram_raddress, sdram_rdata);
         end else begin
            b = exp_q.pop_front();
            if (sdram_rvalid !== b.id || sdram_raddress !== b.addr ||
                sdram_rdata !== b.data || sdram_rtag !== b.tag ||
                sdram_complete !== b.complete || cyc != b.due) begin
               miscompares++;
               $display("[TB] FAIL beat: got id=%0d addr=%h data=%h tag=%h cmp=%b cyc=%0d, want id=%0d addr=%h data=%h tag=%h cmp=%b cyc=%0d",
                        sdram_rvalid, sdram_raddress, sdram_rdata, sdram_rtag,
                        sdram_complete, cyc, b.id, b.addr, b.data, b.tag,
                        b.complete, b.due);
            end
         end
         in_burst = !sdram_complete;
      end else begin
         vectors++;
         if (in_burst || sdram_complete) begin
            miscompares++;
            $display("[TB] FAIL idle cycle: gap=%b complete=%b, want gap=0 complete=0",
                     in_burst, sdram_complete);
         end
         in_burst = 1'b0;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Present one request. Wait (bounded) for ready, then let the next
   // rising edge accept it, and queue the expected beats for reads. The
   // output waited is the number of cycles the request sat with ready low.
   task automatic applyStimulus(input vec_t v, output int waited);
      int          e0;
      int          nbeats;
      logic [3:0]  kk;
      logic [25:0] ba;
      beat_t       b;
      @(negedge clk);
      sdram_request = v.id;
      sdram_address = v.addr;
      sdram_write   = v.wr;
      sdram_burst   = v.burst;
      sdram_wstrb   = v.strb;
      sdram_wdata   = v.wdata;
      waited = 0;
      while (!sdram_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!sdram_ready) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL ready timeout: got ready=0 after %0d cycles, want 1", waited);
         sdram_request = 3'd0;
         return;
      end
      @(posedge clk);
      #1;
      e0 = cyc;
      sdram_request = 3'd0;
      if (!v.wr) begin
         nbeats = v.burst ? 16 : 1;
         for (int k = 0; k < nbeats; k++) begin
            kk = 4'(k);
            ba = v.burst ? {v.addr[25:6], kk, 2'b00} : {v.addr[25:2], 2'b00};
            b.id       = v.id;
            b.addr     = ba;
            // Burst test lines are preloaded with each word's own address.
            b.data     = v.burst ? {6'd0, ba} : v.exp_data;
            b.tag      = v.wdata[8:0];
            b.complete = (k == nbeats - 1);
            b.due      = e0 + 1 + k;
            exp_q.push_back(b);
         end
      end
   endtask

   function automatic vec_t mkW(input logic [2:0] id, input logic [25:0] addr,
                                input logic [3:0] strb, input logic [31:0] data,
                                input int exp_wait);
      vec_t v;
      v.wr = 1'b1; v.burst = 1'b0; v.id = id; v.addr = addr; v.strb = strb;
      v.wdata = data; v.exp_data = 32'd0; v.exp_wait = exp_wait;
      return v;
   endfunction

   function automatic vec_t mkR(input logic [2:0] id, input logic [25:0] addr,
                                input bit burst, input logic [8:0] tag,
                                input logic [31:0] exp, input int exp_wait);
      vec_t v;
      v.wr = 1'b0; v.burst = burst; v.id = id; v.addr = addr; v.strb = 4'hF;
      // Upper wdata bits are junk on reads and must not leak into the tag.
      v.wdata = {23'h555555, tag}; v.exp_data = exp; v.exp_wait = exp_wait;
      return v;
   endfunction

   vec_t tbl[13];

   initial begin
      int w;
      int n;

      // Expected read-after-write results, with the cycles each request
      // waits for ready. A request that follows a single read waits 2 cycles.
      tbl[0]  = mkW(3'd1, 26'h0000100, 4'hF, 32'hDEADBEEF, 0);
      tbl[1]  = mkR(3'd1, 26'h0000100, 1'b0, 9'h1A5, 32'hDEADBEEF, 0);
      tbl[2]  = mkW(3'd3, 26'h0000100, 4'h2, 32'h00005500, 2);
      tbl[3]  = mkR(3'd7, 26'h0000102, 1'b0, 9'h0FF, 32'hDEAD55EF, 0);
      tbl[4]  = mkW(3'd4, 26'h0000104, 4'hF, 32'h11223344, 2);
      tbl[5]  = mkW(3'd4, 26'h0000104, 4'h9, 32'hA1B2C3D4, 0);
      tbl[6]  = mkR(3'd5, 26'h0000104, 1'b0, 9'h000, 32'hA12233D4, 0);
      tbl[7]  = mkW(3'd2, 26'h0004108, 4'hF, 32'hCAFEF00D, 2);
      tbl[8]  = mkR(3'd6, 26'h0000108, 1'b0, 9'h123, 32'hCAFEF00D, 0);
      tbl[9]  = mkW(3'd1, 26'h0003FFC, 4'hF, 32'h0BADF00D, 2);
      tbl[10] = mkR(3'd2, 26'h3FFFFFC, 1'b0, 9'h1FF, 32'h0BADF00D, 0);
      tbl[11] = mkW(3'd6, 26'h0000104, 4'h4, 32'h00EE0000, 2);
      tbl[12] = mkR(3'd3, 26'h2000104, 1'b0, 9'h08C, 32'hA1EE33D4, 0);

      reset_n       = 1'b0;
      sdram_request = 3'd0;
      sdram_address = 26'd0;
      sdram_write   = 1'b0;
      sdram_burst   = 1'b0;
      sdram_wstrb   = 4'h0;
      sdram_wdata   = 32'd0;

      repeat (3) @(negedge clk);
      checkOutput("reset ready", {31'd0, sdram_ready}, 32'd0);
      checkOutput("reset raddress", {6'd0, sdram_raddress}, 32'd0);
      checkOutput("reset rdata", sdram_rdata, 32'd0);
      checkOutput("reset rtag", {23'd0, sdram_rtag}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("ready after reset", {31'd0, sdram_ready}, 32'd1);

      // Reset again while idle
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkOutput("ready in idle reset", {31'd0, sdram_ready}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("ready after idle reset", {31'd0, sdram_ready}, 32'd1);

      for (int i = 0; i < 13; i++) begin
         applyStimulus(tbl[i], w);
         checkOutput($sformatf("wait vec%0d", i), w, tbl[i].exp_wait);
      end

      // Back-to-back preload of a line at 1 write per cycle
      for (int k = 0; k < 16; k++) begin
         applyStimulus(mkW(3'd1, 26'(32'h200 + 4 * k), 4'hF, 32'h200 + 4 * k,
                           0), w);
         checkOutput("preload wait", w, (k == 0) ? 2 : 0);
      end

      // Unaligned burst. A write held behind it waits 17 cycles of ready=0
      // and must not be consumed early.
      applyStimulus(mkR(3'd2, 26'h0000214, 1'b1, 9'h0AA, 32'd0, 0), w);
      checkOutput("burst wait", w, 0);
      applyStimulus(mkW(3'd5, 26'h0000300, 4'hF, 32'h12345678, 0), w);
      checkOutput("ready low after burst", w, 17);
      applyStimulus(mkR(3'd5, 26'h0000300, 1'b0, 9'h042, 32'h12345678, 0), w);
      checkOutput("read after held write", w, 0);

      // Reset in the middle of a burst, just after beat 5
      applyStimulus(mkR(3'd2, 26'h0000200, 1'b1, 9'h155, 32'd0, 0), w);
      checkOutput("burst2 wait", w, 2);
      repeat (6) @(posedge clk);
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      checkOutput("beats left at reset", exp_q.size(), 10);
      exp_q.delete();
      #1;
      checkOutput("rvalid at reset", {29'd0, sdram_rvalid}, 32'd0);
      checkOutput("complete at reset", {31'd0, sdram_complete}, 32'd0);
      checkOutput("ready at reset", {31'd0, sdram_ready}, 32'd0);
      checkOutput("rdata at reset", sdram_rdata, 32'd0);
      checkOutput("rtag at reset", {23'd0, sdram_rtag}, 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("ready after burst reset", {31'd0, sdram_ready}, 32'd1);
      applyStimulus(mkR(3'd1, 26'h0000100, 1'b0, 9'h1A5, 32'hDEAD55EF, 0), w);
      checkOutput("read after burst reset", w, 0);

      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("beats outstanding", exp_q.size(), 0);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, want finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/sdram_bram_responder.md
Name: sdram_bram_responder

Overview:
- Responder end of the SDRAM request/response bus that the arbiter drives. It stands in for the SDRAM controller so the arbiter and its masters can be simulated and run without the external SDRAM.
- Backed by on-chip byte-enabled block RAM.
- Accepts single-word reads/writes and 64-byte (16-beat) read bursts.
- Returns read data tagged with the originating master ID, the address and the request tag.

Parameters:
- WORD_ADDR_BITS, 12, log2 of memory depth in 32-bit words (default 16 KB); higher address bits ignored, so addresses alias modulo the memory size.
- BURST_BEATS, 16, beats per burst read (fixed 64 bytes; must equal 16).
- REFRESH_INTERVAL, 512, cycles between emulated refresh stalls (used only with SDRAM_REFRESH_EN).
- REFRESH_CYCLES, 8, length of each emulated refresh stall in cycles (used only with SDRAM_REFRESH_EN).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- sdram_request  in  3  master ID of the presented request; 0 = none.
- sdram_ready  out  1  responder will consume the request presented this cycle.
- sdram_address  in  26  byte address.
- sdram_write  in  1  1 = write, 0 = read.
- sdram_burst  in  1  1 = 16-beat read burst, 0 = single word.
- sdram_wstrb  in  4  byte enables for writes.
- sdram_wdata  in  32  write data; bits [8:0] are the tag for reads.
- sdram_rvalid  out  3  master ID owning the current read beat; 0 = no beat.
- sdram_raddress  out  26  byte address of the current beat.
- sdram_rdata  out  32  read data.
- sdram_rtag  out  9  tag captured from wdata[8:0] at acceptance.
- sdram_complete  out  1  high on the final beat of a transaction.

Behaviour:
- Acceptance: a request is accepted on a rising edge where sdram_ready=1 and sdram_request≠0.
  - Any nonzero ID is legal and is echoed unchanged on sdram_rvalid.
  - sdram_ready is registered and depends only on internal state, never on inputs in the same cycle.
- States: IDLE, READ, STALL (STALL exists only with SDRAM_REFRESH_EN).
- IDLE:
  - sdram_ready=1.
  - Accepted write: bytes selected by wstrb written at the acceptance edge to word address[WORD_ADDR_BITS+1:2]. Stays in IDLE, so back-to-back writes sustain 1 per cycle. No response beat. sdram_burst is ignored for writes.
  - Accepted read: latch ID, tag, address and burst; go to READ; sdram_ready=0 from the next cycle.
- READ:
  - RAM read address is issued at the acceptance edge. Beat k appears in the cycle after edge E0+1+k, where E0 is the acceptance edge. First-beat latency is therefore 2 cycles; beats are contiguous, one per cycle, with no gaps.
  - Single read: 1 beat; raddress = {address[25:2],2'b00}; sdram_complete=1.
  - Burst read: 16 beats, line-aligned. raddress = {address[25:6], k[3:0], 2'b00}, so address[5:0] is ignored. sdram_complete=1 only on beat 15.
  - Beat counter is 4 bits and must not wrap past 15.
  - Every beat carries the latched ID and tag.
  - Ready returns to 1 in the cycle after the final beat. A request held by the arbiter is accepted at the next edge, giving one idle cycle between transactions.
- Outputs when no beat is active:
  - sdram_rvalid=0 and sdram_complete=0.
  - raddress, rdata and rtag hold their last values.
- Reset (reset_n=0, at any time including mid-burst):
  - Outputs: sdram_ready=0, sdram_rvalid=0, sdram_complete=0, raddress/rdata/rtag=0.
  - Any in-flight burst is abandoned; no further beats and no complete are issued.
  - Memory contents are not cleared.
  - First edge after reset_n rises: state is IDLE and sdram_ready=1 from that cycle.
- sdram_request≠0 while ready=0: ignored, not consumed.

Optional Feature:
- Macro SDRAM_REFRESH_EN.
- Defined:
  - A free-running counter enters STALL every REFRESH_INTERVAL cycles, for REFRESH_CYCLES cycles, with sdram_ready=0.
  - If the counter expires during READ, STALL is deferred until the transaction's final beat completes. Bursts are never split.
  - STALL is not entered if a request is being accepted that same edge; it is entered on the next IDLE cycle instead.
  - The counter is reset by reset_n.
- Undefined: no STALL state, no counter; IDLE is left only for READ.

Test Plan:
- Reset then write: assert reset_n=0 mid-idle, release. Write ID=1, addr 0x100, wdata 0xDEADBEEF, wstrb 0xF -> ready=1 throughout, no rvalid.
- Single read: read ID=1, addr 0x100, tag 0x1A5 -> 2 cycles later a single beat with rvalid=1, rdata=0xDEADBEEF, rtag=0x1A5, raddress=0x100, complete=1.
- Partial write: write wstrb 0x2, wdata 0x0000_5500 to 0x100, then read -> rdata=0xDEAD55EF.
- Burst read: preload words 0x200..0x23C with their own addresses. Burst read ID=2, addr 0x214 -> 16 consecutive beats, rvalid=2, raddress 0x200..0x23C, rdata equal to raddress, complete only on beat 15. Ready=0 for 17 cycles after acceptance.
- Reset mid-burst: burst read ID=2; pull reset_n low after beat 5 -> rvalid=0 immediately and no complete. After release, a single read of 0x100 returns 0xDEAD55EF.
- Refresh stall (SDRAM_REFRESH_EN, REFRESH_INTERVAL=64, REFRESH_CYCLES=8): present continuous ID=1 writes -> ready low 8 cycles every 64. A burst spanning the expiry point completes all 16 beats before the stall.
